nd_array_assembler: RTL and testbench

Receives a stream of scalar elements and assembles them into a packed three-dimensional array `[D2][D1][D0]` of `EW`-bit elements, the inverse of the flattening and index-gathering logic that produces packed ND-array buses. It sits between an element-serial producer and a consumer that expects a whole ND array per transfer. Two internal banks let the next array fill while the previous one waits for the consumer. Frame framing is checked against `I_last`, and malformed frames are dropped.

---
 rtl/nd_array_assembler.sv | 127 ++++++++++++
 tb/tb_nd_array_assembler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nd_array_assembler.sv
// nd_array_assembler: collects a stream of EW-bit elements into a packed
// [D2][D1][D0] array. There are two banks, so one array can fill while the
// other waits for the consumer. A frame whose I_last does not line up with
// its final element is dropped, and O_err pulses for one cycle.
module nd_array_assembler #(
  parameter int D2 = 3,
  parameter int D1 = 4,
  parameter int D0 = 6,
  parameter int EW = 1
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESETN,
  input  logic                     I_valid,
  output logic                     I_ready,
  input  logic [EW-1:0]            I_data,
  input  logic                     I_last,
  output logic                     O_valid,
  input  logic                     O_ready,
  output logic [D2*D1*D0*EW-1:0]   O_data,
  output logic                     O_err
);

  localparam int unsigned NB = D2 * D1 * D0 * EW;
  localparam int unsigned W0 = (D0 > 1) ? $clog2(D0) : 1;
  localparam int unsigned W1 = (D1 > 1) ? $clog2(D1) : 1;
  localparam int unsigned W2 = (D2 > 1) ? $clog2(D2) : 1;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;

  logic [W0-1:0] i0;
  logic [W1-1:0] i1;
  logic [W2-1:0] i2;
  logic          wb;
  logic          rb;
  logic [1:0]    full;
  logic [NB-1:0] bank [2];

  logic          accept;
  logic          last0;
  logic          last1;
  logic          last2;
  logic          at_final;
  logic          complete;
  logic          frame_err;
  logic          drain;
  logic [BW-1:0] widx;

  // Handshake, framing decode and the write bit offset of the current element
  always_comb begin
    I_ready   = !full[wb];
    O_valid   = full[rb];
    O_data    = bank[rb];
    accept    = I_valid && I_ready;
    last0     = (i0 == W0'(D0 - 1));
    last1     = (i1 == W1'(D1 - 1));
    last2     = (i2 == W2'(D2 - 1));
    at_final  = last0 && last1 && last2;
    complete  = accept && at_final && I_last;
    frame_err = accept && (at_final != I_last);
    drain     = O_valid && O_ready;
    widx      = BW'(((32'(i2) * 32'(D1) + 32'(i1)) * 32'(D0) + 32'(i0)) * 32'(EW));
  end

  // Row-major write index, i0 fastest. It returns to [0][0][0] at the end of
  // every frame, whether the frame completed or was dropped.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      i0 <= '0;
      i1 <= '0;
      i2 <= '0;
    end else if (accept) begin
      if (complete || frame_err) begin
        i0 <= '0;
        i1 <= '0;
        i2 <= '0;
      end else if (last0) begin
        i0 <= '0;
        if (last1) begin
          i1 <= '0;
          i2 <= i2 + W2'(1);
        end else begin
          i1 <= i1 + W1'(1);
        end
      end else begin
        i0 <= i0 + W0'(1);
      end
    end
  end

  // Bank pointers and full flags. A completion and a drain can never target
  // the same bank in one cycle, so both updates can be applied independently.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      wb   <= 1'b0;
      rb   <= 1'b0;
      full <= '0;
    end else begin
      if (complete) wb <= !wb;
      if (drain)    rb <= !rb;
      for (int unsigned b = 0; b < 2; b++) begin
        if (complete && (wb == 1'(b)))
          full[b] <= 1'b1;
        else if (drain && (rb == 1'(b)))
          full[b] <= 1'b0;
      end
    end
  end

  // Element storage. An early-I_last element is not stored; anything a
  // dropped frame leaves behind is overwritten before that bank is presented.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      bank[0] <= '0;
      bank[1] <= '0;
    end else if (accept && !(I_last && !at_final)) begin
      bank[wb][widx +: EW] <= I_data;
    end
  end

  // Framing-error pulse, high for the cycle after the offending accept
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN)
      O_err <= 1'b0;
    else
      O_err <= frame_err;
  end

endmodule

// File: tb/tb_nd_array_assembler.sv
// Testbench for nd_array_assembler. A queue of whole frames acts as the
// reference model.
module tb_nd_array_assembler;

  localparam int D2 = 3;
  localparam int D1 = 4;
  localparam int D0 = 6;
  localparam int EW = 1;
  localparam int N  = D2 * D1 * D0;

  logic          CLK = 1'b0;
  logic          ASYNCRESETN;
  logic          I_valid;
  logic          I_ready;
  logic [EW-1:0] I_data;
  logic          I_last;
  logic          O_valid;
  logic          O_ready;
  logic [N-1:0]  O_data;
  logic          O_err;

  nd_array_assembler #(.D2(D2), .D1(D1), .D0(D0), .EW(EW)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .I_valid(I_valid), .I_ready(I_ready), .I_data(I_data), .I_last(I_last),
    .O_valid(O_valid), .O_ready(O_ready), .O_data(O_data), .O_err(O_err)
  );

  always #5 CLK = ~CLK;

  // Reference model: completed frames waiting for the consumer (at most 2),
  // the partially collected frame, and the expected error pulse.
  logic [N-1:0] q[$];
  logic [N-1:0] part;
  int           pcnt;
  bit           err_exp;
  int           vec;
  int           miss;

  task automatic model_reset();
    q.delete();
    part    = '0;
    pcnt    = 0;
    err_exp = 1'b0;
  endtask

  // Drives one cycle, advances the model across the edge, and returns at
  // posedge+1 with the model showing what the DUT should now present.
  task automatic tick(input bit v, input bit d, input bit l, input bit r, output bit acc);
    bit drn;
    I_valid = v; I_data = d; I_last = l; O_ready = r;
    @(posedge CLK);
    acc     = v && (q.size() < 2);
    drn     = r && (q.size() > 0);
    err_exp = 1'b0;
    if (drn) q.delete(0);
    if (acc) begin
      if (l && pcnt == N - 1) begin
        part[pcnt] = d;
        q.push_back(part);
        pcnt = 0;
      end else if (l || pcnt == N - 1) begin
        err_exp = 1'b1;
        pcnt    = 0;
      end else begin
        part[pcnt] = d;
        pcnt++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    ASYNCRESETN = 1'b0;
    I_valid = 1'b0; I_data = '0; I_last = 1'b0; O_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    vec++; if (O_valid !== 1'b0) begin miss++; $display("FAIL reset_valid: got %b want 0", O_valid); end
    vec++; if (I_ready !== 1'b1) begin miss++; $display("FAIL reset_ready: got %b want 1", I_ready); end
    vec++; if (O_data !== '0) begin miss++; $display("FAIL reset_data: got %h want 0", O_data); end
    vec++; if (O_err !== 1'b0) begin miss++; $display("FAIL reset_err: got %b want 0", O_err); end
    @(negedge CLK) ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_single_frame();
    logic [N-1:0] gold;
    bit a;
    for (int b = 0; b < N; b++) gold[b] = 1'(b % 2);
    for (int n = 0; n < N; n++) begin
      tick(1'b1, 1'(n % 2), n == N - 1, 1'b1, a);
      if (n < N - 1) begin
        vec++; if (O_valid !== 1'b0) begin miss++; $display("FAIL single_early_valid n=%0d: got %b want 0", n, O_valid); end
        vec++; if (I_ready !== 1'b1) begin miss++; $display("FAIL single_ready n=%0d: got %b want 1", n, I_ready); end
      end
    end
    vec++; if (O_valid !== 1'b1) begin miss++; $display("FAIL single_valid: got %b want 1", O_valid); end
    vec++; if (O_data !== gold) begin miss++; $display("FAIL single_data: got %h want %h", O_data, gold); end
    vec++; if (O_err !== 1'b0) begin miss++; $display("FAIL single_err: got %b want 0", O_err); end
    tick(1'b0, 1'b0, 1'b0, 1'b1, a);
    vec++; if (O_valid !== 1'b0) begin miss++; $display("FAIL single_drained: got %b want 0", O_valid); end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] fr[3];
    int idx, guard, outn;
    bit a, r, d;
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < N; b++) fr[f][b] = 1'($urandom_range(0, 1));
    idx = 0; guard = 0;
    while (idx < 2 * N && guard < 400) begin
      tick(1'b1, fr[idx / N][idx % N], (idx % N) == N - 1, 1'b0, a);
      if (a) idx++;
      guard++;
    end
    vec++; if (I_ready !== 1'b0) begin miss++; $display("FAIL bp_ready_after_144: got %b want 0", I_ready); end
    vec++; if (O_data !== fr[0]) begin miss++; $display("FAIL bp_head: got %h want %h", O_data, fr[0]); end
    repeat (5) begin
      tick(1'b1, fr[2][0], 1'b0, 1'b0, a);
      vec++; if (I_ready !== 1'b0) begin miss++; $display("FAIL bp_stall_ready: got %b want 0", I_ready); end
      vec++; if (O_data !== fr[0]) begin miss++; $display("FAIL bp_stable: got %h want %h", O_data, fr[0]); end
    end
    outn = 0; guard = 0;
    while ((idx < 3 * N || q.size() > 0) && guard < 2000) begin
      r = 1'($urandom_range(0, 1));
      if (r && O_valid === 1'b1) begin
        vec++;
        if (outn > 2) begin miss++; $display("FAIL bp_extra_frame: got frame %0d want at most 3", outn + 1); end
        else if (O_data !== fr[outn]) begin miss++; $display("FAIL bp_order f%0d: got %h want %h", outn, O_data, fr[outn]); end
        outn++;
      end
      d = (idx < 3 * N) ? fr[idx / N][idx % N] : 1'b0;
      tick(idx < 3 * N, d, (idx % N) == N - 1, r, a);
      if (a) idx++;
      guard++;
    end
    vec++; if (outn != 3) begin miss++; $display("FAIL bp_frame_count: got %0d want 3", outn); end
  endtask

  task automatic test_early_last();
    logic [N-1:0] gold;
    bit a;
    for (int n = 0; n < 10; n++) tick(1'b1, 1'($urandom_range(0, 1)), n == 9, 1'b1, a);
    vec++; if (O_err !== 1'b1) begin miss++; $display("FAIL early_err: got %b want 1", O_err); end
    vec++; if (O_valid !== 1'b0) begin miss++; $display("FAIL early_valid: got %b want 0", O_valid); end
    tick(1'b0, 1'b0, 1'b0, 1'b1, a);
    vec++; if (O_err !== 1'b0) begin miss++; $display("FAIL early_err_width: got %b want 0", O_err); end
    for (int b = 0; b < N; b++) gold[b] = 1'($urandom_range(0, 1));
    for (int n = 0; n < N; n++) tick(1'b1, gold[n], n == N - 1, 1'b0, a);
    vec++; if (O_valid !== 1'b1) begin miss++; $display("FAIL early_next_valid: got %b want 1", O_valid); end
    vec++; if (O_data !== gold) begin miss++; $display("FAIL early_next_data: got %h want %h", O_data, gold); end
    tick(1'b0, 1'b0, 1'b0, 1'b1, a);
  endtask

  task automatic test_missing_last();
    logic [N-1:0] gold;
    bit a;
    for (int n = 0; n < N; n++) tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, a);
    vec++; if (O_err !== 1'b1) begin miss++; $display("FAIL miss_err: got %b want 1", O_err); end
    vec++; if (O_valid !== 1'b0) begin miss++; $display("FAIL miss_valid: got %b want 0", O_valid); end
    tick(1'b0, 1'b0, 1'b0, 1'b1, a);
    vec++; if (O_err !== 1'b0) begin miss++; $display("FAIL miss_err_width: got %b want 0", O_err); end
    for (int b = 0; b < N; b++) gold[b] = 1'($urandom_range(0, 1));
    for (int n = 0; n < N; n++) tick(1'b1, gold[n], n == N - 1, 1'b0, a);
    vec++; if (O_data !== gold) begin miss++; $display("FAIL miss_next_data: got %h want %h", O_data, gold); end
    tick(1'b0, 1'b0, 1'b0, 1'b1, a);
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] fa, fb;
    bit a;
    for (int b = 0; b < N; b++) begin
      fa[b] = 1'($urandom_range(0, 1));
      fb[b] = ~fa[b];
    end
    for (int n = 0; n < N; n++) tick(1'b1, fa[n], n == N - 1, 1'b0, a);
    for (int n = 0; n < N - 1; n++) begin
      tick(1'b1, fb[n], 1'b0, 1'b0, a);
      vec++; if (O_data !== fa) begin miss++; $display("FAIL simul_hold n=%0d: got %h want %h", n, O_data, fa); end
    end
    tick(1'b1, fb[N-1], 1'b1, 1'b1, a);
    vec++; if (O_valid !== 1'b1) begin miss++; $display("FAIL simul_valid: got %b want 1", O_valid); end
    vec++; if (O_data !== fb) begin miss++; $display("FAIL simul_data: got %h want %h", O_data, fb); end
    tick(1'b0, 1'b0, 1'b0, 1'b1, a);
    vec++; if (O_valid !== 1'b0) begin miss++; $display("FAIL simul_drained: got %b want 0", O_valid); end
  endtask

  task automatic test_reset_midframe();
    logic [N-1:0] gold;
    bit a;
    for (int n = 0; n < N; n++) tick(1'b1, 1'($urandom_range(0, 1)), n == N - 1, 1'b0, a);
    for (int n = 0; n < 30; n++) tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, a);
    #2;
    ASYNCRESETN = 1'b0;
    I_valid = 1'b0;
    #1;
    model_reset();
    vec++; if (O_valid !== 1'b0) begin miss++; $display("FAIL rstmid_valid: got %b want 0", O_valid); end
    vec++; if (I_ready !== 1'b1) begin miss++; $display("FAIL rstmid_ready: got %b want 1", I_ready); end
    vec++; if (O_data !== '0) begin miss++; $display("FAIL rstmid_data: got %h want 0", O_data); end
    @(posedge CLK);
    @(negedge CLK) ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;
    for (int b = 0; b < N; b++) gold[b] = 1'($urandom_range(0, 1));
    for (int n = 0; n < N; n++) tick(1'b1, gold[n], n == N - 1, 1'b0, a);
    vec++; if (O_valid !== 1'b1) begin miss++; $display("FAIL rstmid_next_valid: got %b want 1", O_valid); end
    vec++; if (O_data !== gold) begin miss++; $display("FAIL rstmid_next_data: got %h want %h", O_data, gold); end
    tick(1'b0, 1'b0, 1'b0, 1'b1, a);
  endtask

  task automatic test_random();
    bit a, v, r, l;
    for (int c = 0; c < 1500; c++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      l = (pcnt == N - 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 79) == 0);
      tick(v, 1'($urandom_range(0, 1)), l, r, a);
      vec++; if (I_ready !== (q.size() < 2)) begin miss++; $display("FAIL rand_ready c=%0d: got %b want %b", c, I_ready, q.size() < 2); end
      vec++; if (O_valid !== (q.size() > 0)) begin miss++; $display("FAIL rand_valid c=%0d: got %b want %b", c, O_valid, q.size() > 0); end
      vec++; if (O_err !== err_exp) begin miss++; $display("FAIL rand_err c=%0d: got %b want %b", c, O_err, err_exp); end
      if (q.size() > 0) begin
        vec++; if (O_data !== q[0]) begin miss++; $display("FAIL rand_data c=%0d: got %h want %h", c, O_data, q[0]); end
      end
    end
  endtask

  initial begin
    vec = 0;
    miss = 0;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_simultaneous();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
